seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver for DIGITS common-anode/cathode digits. It takes a packed hex value plus per-digit decimal points and decodes the full 0–F range, not just BCD 0–9. It scans one digit at a time at a programmable rate, with optional leading-zero suppression and tear-free frame-synchronous update. It sits between any value-producing block (counter, ALU, BCD converter) and the board's shared segment bus and digit-enable lines.

---
 rtl/seg7_scan_driver.sv | 126 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: hex decode, leading-zero blanking and
// frame-synchronous (tear-free) display update with registered outputs.
module seg7_scan_driver #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned CLK_DIV    = 1000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0]   CntMax = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0]   IdxMax = IdxW'(DIGITS - 1);
  localparam logic [6:0]        SegOff = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AnOff  = {DIGITS{ACTIVE_LOW}};

  logic [CntW-1:0]     cnt_q;
  logic [IdxW-1:0]     idx_q;
  logic [4*DIGITS-1:0] disp_val_q, pend_val_q;
  logic [DIGITS-1:0]   disp_dp_q, pend_dp_q;
  logic                pend_q;
  logic                wrap_q;

  logic                tick, wrap;
  logic [3:0]          nib;
  logic [6:0]          font;
  logic                all_zero;
  logic [DIGITS-1:0]   zero_from;
  logic                blank;
  logic [DIGITS-1:0]   an_next;

  assign tick = (cnt_q == CntMax);
  assign wrap = tick && (idx_q == IdxMax);

  // zero_from[k]: nibble k and every more-significant nibble are zero
  always_comb begin
    all_zero  = 1'b1;
    zero_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (disp_val_q[4*k +: 4] == 4'h0);
      zero_from[k] = all_zero;
    end
  end

  assign nib     = disp_val_q[{idx_q, 2'b00} +: 4];
  assign blank   = lz_en && (idx_q != '0) && zero_from[idx_q];
  assign an_next = DIGITS'(1) << idx_q;

  always_comb begin
    font = 7'h00;
    case (nib)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      4'hF: font = 7'h71;
      default: font = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      wrap_q     <= 1'b0;
      seg        <= SegOff;
      dp         <= ACTIVE_LOW;
      an         <= AnOff;
      frame_done <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_q <= (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end

      // A load coinciding with the frame boundary skips pending entirely
      if (wrap && load) begin
        disp_val_q <= value_in;
        disp_dp_q  <= dp_in;
        pend_q     <= 1'b0;
      end else if (wrap && pend_q) begin
        disp_val_q <= pend_val_q;
        disp_dp_q  <= pend_dp_q;
        pend_q     <= 1'b0;
      end else if (load) begin
        pend_val_q <= value_in;
        pend_dp_q  <= dp_in;
        pend_q     <= 1'b1;
      end

      // Outputs lag the index by one cycle, so the pulse is delayed to match
      wrap_q     <= wrap;
      frame_done <= wrap_q;
      seg        <= (blank ? 7'h00 : font) ^ SegOff;
      dp         <= disp_dp_q[idx_q] ^ ACTIVE_LOW;
      an         <= an_next ^ AnOff;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver: a cycle model pushes the expected
// outputs at each clock edge, and they are compared on the following falling edge.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FRAME   = DIGITS * CLK_DIV;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  logic        load_al = 1'b0;
  logic [15:0] value_al = '0;
  logic [3:0]  dp_al_in = '0;
  logic        lz_al = 1'b0;
  logic [6:0]  seg_al;
  logic        dp_al;
  logic [3:0]  an_al;
  logic        frame_done_al;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  exp_t        q[$];
  int unsigned m_cnt = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_ddp = '0, m_pdp = '0;
  logic        m_pf = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in), .lz_en(lz_en),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .load(load_al), .value_in(value_al), .dp_in(dp_al_in),
    .lz_en(lz_al), .seg(seg_al), .dp(dp_al), .an(an_al), .frame_done(frame_done_al)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] font_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // p = clock edges since reset release before the edge being predicted
  function automatic exp_t expect_out(input int unsigned p, input logic [15:0] v,
                                      input logic [3:0] dps, input logic lz);
    exp_t        e;
    int unsigned d;
    logic [15:0] upper;
    d     = (p / CLK_DIV) % DIGITS;
    upper = v >> (4 * d);
    e.an  = 4'(1 << d);
    e.dp  = dps[d];
    e.seg = (lz && d != 0 && upper == 16'h0) ? 7'h00 : font_of(upper[3:0]);
    e.fd  = (p != 0) && (p % FRAME == 0);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_disp <= '0;
      m_ddp  <= '0;
      m_pend <= '0;
      m_pdp  <= '0;
      m_pf   <= 1'b0;
      q.delete();
    end else begin
      q.push_back(expect_out(m_cnt, m_disp, m_ddp, lz_en));
      m_cnt <= m_cnt + 1;
      if ((m_cnt + 1) % FRAME == 0) begin
        m_pf <= 1'b0;
        if (load) begin
          m_disp <= value_in;
          m_ddp  <= dp_in;
        end else if (m_pf) begin
          m_disp <= m_pend;
          m_ddp  <= m_pdp;
        end
      end else if (load) begin
        m_pend <= value_in;
        m_pdp  <= dp_in;
        m_pf   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      check("seg", {25'd0, seg}, {25'd0, q[0].seg});
      check("dp", {31'd0, dp}, {31'd0, q[0].dp});
      check("an", {28'd0, an}, {28'd0, q[0].an});
      check("frame_done", {31'd0, frame_done}, {31'd0, q[0].fd});
      void'(q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Wait until the next clock edge is at frame position r
  task automatic wait_pos(input int unsigned r);
    int n = 0;
    while ((m_cnt % FRAME) != r && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * FRAME) check("wait_pos_timeout", n, 0);
  endtask

  initial begin
    int n_d2;
    int fd_cnt;

    step(3);
    check("rst_seg", {25'd0, seg}, 32'h0);
    check("rst_an", {28'd0, an}, 32'h0);
    check("rst_dp", {31'd0, dp}, 32'h0);
    check("rst_fd", {31'd0, frame_done}, 32'h0);
    check("rst_al_seg", {25'd0, seg_al}, 32'h7F);
    check("rst_al_an", {28'd0, an_al}, 32'hF);
    check("rst_al_dp", {31'd0, dp_al}, 32'h1);
    rst = 1'b0;
    step(2 * FRAME);

    // Decode sweep across the full hex range
    do_load(16'h0123, 4'b0001);
    step(2 * FRAME);
    do_load(16'h4567, 4'b0010);
    step(2 * FRAME);
    do_load(16'h89AB, 4'b1000);
    step(2 * FRAME);
    do_load(16'hCDEF, 4'b0101);
    step(2 * FRAME);

    // Mid-frame load, then two loads within one frame
    wait_pos(6);
    do_load(16'h1234, 4'b0000);
    step(2 * FRAME);
    wait_pos(2);
    do_load(16'h5555, 4'b1111);
    step(3);
    do_load(16'hA0B1, 4'b0010);
    step(2 * FRAME);

    // Load on the boundary edge bypasses pending
    wait_pos(FRAME - 1);
    do_load(16'h9876, 4'b0100);
    step(FRAME + 3);

    // Leading-zero suppression, including a live lz_en toggle
    lz_en = 1'b1;
    do_load(16'h0040, 4'b1000);
    step(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    step(FRAME + 5);
    lz_en = 1'b0;
    step(5);
    lz_en = 1'b1;
    step(FRAME);
    do_load(16'h0305, 4'b0000);
    step(2 * FRAME);
    lz_en = 1'b0;

    // Asynchronous reset while digit 2 is driven and a load is pending
    wait_pos(1);
    do_load(16'hBEEF, 4'b1111);
    wait_pos(10);
    #2 rst = 1'b1;
    #1;
    check("arst_seg", {25'd0, seg}, 32'h0);
    check("arst_an", {28'd0, an}, 32'h0);
    check("arst_dp", {31'd0, dp}, 32'h0);
    check("arst_al_an", {28'd0, an_al}, 32'hF);
    step(2);
    rst = 1'b0;
    step(3 * FRAME);

    // Inverted polarity instance: digit 2 shows 8 with its decimal point
    value_al = 16'h0800;
    dp_al_in = 4'b0100;
    load_al  = 1'b1;
    @(negedge clk);
    load_al  = 1'b0;
    step(FRAME + 4);
    n_d2   = 0;
    fd_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      check("al_an_onecold", $countones(~an_al), 1);
      if (an_al == 4'b1011) begin
        n_d2++;
        check("al_seg_d2", {25'd0, seg_al}, 32'h00);
        check("al_dp_d2", {31'd0, dp_al}, 32'h0);
      end else begin
        check("al_seg", {25'd0, seg_al}, 32'h40);
        check("al_dp", {31'd0, dp_al}, 32'h1);
      end
      fd_cnt += int'(frame_done_al);
    end
    check("al_d2_cycles", n_d2, CLK_DIV);
    check("al_fd_count", fd_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
